// File: rtl/pwm_speed_decoder_pkg.sv
// Definitions shared by the fan PWM generator and the PWM speed decoder, so
// both ends agree on the PWM period and the duty-code width.
package chs_pkg;

  localparam int PWM_PERIOD = 256;

  typedef logic [7:0] speed_t;

  localparam speed_t SPEED_MIN = 8'h00;
  localparam speed_t SPEED_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ACQUIRE,
    MEASURE,
    STUCK_LOW,
    STUCK_HIGH
  } dec_state_e;

endpackage

// File: rtl/pwm_speed_decoder_if.sv
// Feedback-path bundle between the PWM line source and the speed decoder:
// the raw PWM line in, the recovered code and health flags out.
interface pwm_speed_decoder_if;
  import chs_pkg::*;

  logic   pwm_in;
  speed_t speed;
  logic   speed_valid;
  logic   period_err;
  logic   stuck_low;
  logic   stuck_high;

  modport master (
    output pwm_in,
    input  speed,
    input  speed_valid,
    input  period_err,
    input  stuck_low,
    input  stuck_high
  );

  modport slave (
    input  pwm_in,
    output speed,
    output speed_valid,
    output period_err,
    output stuck_low,
    output stuck_high
  );

endinterface

// File: rtl/pwm_speed_decoder_sync_edge.sv
// Synchronizer for the asynchronous PWM line plus rise/fall detection on the
// synchronized level. SYNC_STAGES must be at least 2.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Recovers the 8-bit duty code from a fan PWM line by timing the high phase
// and the rise-to-rise period, and flags stuck or off-period lines.
module pwm_speed_decoder
  import chs_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              arst,
  pwm_speed_decoder_if.slave dec_if
);

  localparam int CNT_W = $clog2(2 * PERIOD) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_STUCK = CNT_W'(2 * PERIOD - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The rise cycle itself is not counted by hi_cnt, so add it back here.
  function automatic speed_t sat_speed(input logic [CNT_W-1:0] hi);
    if (hi >= CNT_W'(SPEED_MAX)) begin
      return SPEED_MAX;
    end
    return speed_t'(hi + CNT_W'(1));
  endfunction

  function automatic logic in_tol(input logic [CNT_W-1:0] per);
    int meas;
    meas = int'(per) + 1;
    return (meas >= PERIOD - TOL) && (meas <= PERIOD + TOL);
  endfunction

  logic level;
  logic rise;
  logic fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .arst   (arst),
    .pwm_i  (dec_if.pwm_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  dec_state_e       state_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_d;
  speed_t           cap_q;
  logic             upd_q;
  logic             err_q;
  speed_t           speed_q;
  logic             speed_valid_q;
  logic             period_err_q;
  logic             stuck_low_q;
  logic             stuck_high_q;

  always_comb begin
    per_cnt_d = sat_inc(per_cnt_q);
    hi_cnt_d  = sat_inc(hi_cnt_q);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q       <= ACQUIRE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      cap_q         <= SPEED_MIN;
      upd_q         <= 1'b0;
      err_q         <= 1'b0;
      speed_q       <= SPEED_MIN;
      speed_valid_q <= 1'b0;
      period_err_q  <= 1'b0;
      stuck_low_q   <= 1'b0;
      stuck_high_q  <= 1'b0;
    end else begin
      // Period verdicts taken on a rise are published one cycle later.
      speed_valid_q <= upd_q;
      period_err_q  <= err_q;
      upd_q         <= 1'b0;
      err_q         <= 1'b0;
      if (upd_q) begin
        speed_q <= cap_q;
      end

      case (state_q)
        ACQUIRE: begin
          if (rise) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            state_q   <= MEASURE;
          end else if (fall) begin
            per_cnt_q <= '0;
          end else if (per_cnt_q >= CNT_STUCK) begin
            speed_valid_q <= 1'b1;
            if (level) begin
              speed_q      <= SPEED_MAX;
              stuck_high_q <= 1'b1;
              state_q      <= STUCK_HIGH;
            end else begin
              speed_q     <= SPEED_MIN;
              stuck_low_q <= 1'b1;
              state_q     <= STUCK_LOW;
            end
          end else begin
            per_cnt_q <= per_cnt_d;
          end
        end

        MEASURE: begin
          // A rise always closes the period, even when it coincides with the
          // stuck timeout.
          if (rise) begin
            upd_q     <= in_tol(per_cnt_q);
            err_q     <= ~in_tol(per_cnt_q);
            cap_q     <= sat_speed(hi_cnt_q);
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end else if (per_cnt_q >= CNT_STUCK) begin
            per_cnt_q     <= per_cnt_d;
            speed_valid_q <= 1'b1;
            if (level) begin
              speed_q      <= SPEED_MAX;
              stuck_high_q <= 1'b1;
              state_q      <= STUCK_HIGH;
            end else begin
              speed_q     <= SPEED_MIN;
              stuck_low_q <= 1'b1;
              state_q     <= STUCK_LOW;
            end
          end else begin
            per_cnt_q <= per_cnt_d;
            if (level) begin
              hi_cnt_q <= hi_cnt_d;
            end
          end
        end

        STUCK_LOW: begin
          if (rise) begin
            stuck_low_q <= 1'b0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            state_q     <= MEASURE;
          end
        end

        STUCK_HIGH: begin
          if (fall) begin
            stuck_high_q <= 1'b0;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            state_q      <= ACQUIRE;
          end
        end

        default: begin
          state_q <= ACQUIRE;
        end
      endcase
    end
  end

  assign dec_if.speed       = speed_q;
  assign dec_if.speed_valid = speed_valid_q;
  assign dec_if.period_err  = period_err_q;
  assign dec_if.stuck_low   = stuck_low_q;
  assign dec_if.stuck_high  = stuck_high_q;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Bench for pwm_speed_decoder: table of generator codes, hand sequences for
// stuck lines, wrong periods and mid-period reset, and a randomized stream
// checked against an edge-timing reference model.
module tb_pwm_speed_decoder;
  import chs_pkg::*;

  localparam int P   = 256;
  localparam int TOL = 2;
  localparam int NS  = 2;

  logic clk  = 1'b0;
  logic arst = 1'b0;

  always #5 clk = ~clk;

  pwm_speed_decoder_if bus ();

  pwm_speed_decoder #(
    .PERIOD     (P),
    .TOL        (TOL),
    .SYNC_STAGES(NS)
  ) dut (
    .clk   (clk),
    .arst  (arst),
    .dec_if(bus)
  );

  typedef struct {
    int     code;
    speed_t exp_speed;
  } vec_t;

  typedef struct {
    int     cyc;
    bit     err;
    speed_t spd;
  } ev_t;

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  bit     mon_en   = 1'b0;
  int     g_ph     = 0;

  // Reference model: remembers the last sampled rise and counts high samples
  // since then; each closing rise yields one expected event.
  bit     m_prev;
  bit     m_armed;
  int     m_rise;
  int     m_hi;
  speed_t m_speed;
  ev_t    expq[$];

  vec_t   tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input speed_t s);
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_rise  = 0;
    m_hi    = 0;
    m_speed = s;
    expq.delete();
  endtask

  task automatic model_edge(input bit v);
    ev_t e;
    int  per;
    if (v && !m_prev) begin
      if (m_armed) begin
        per   = cyc - m_rise;
        e.cyc = cyc + NS + 1;
        e.err = !((per >= P - TOL) && (per <= P + TOL));
        e.spd = (m_hi > 255) ? speed_t'(255) : speed_t'(m_hi);
        expq.push_back(e);
      end
      m_armed = 1'b1;
      m_rise  = cyc;
      m_hi    = 0;
    end
    if (v) m_hi++;
    m_prev = v;
  endtask

  task automatic monitor();
    ev_t e;
    bit  ev_v;
    bit  ev_e;
    ev_v = 1'b0;
    ev_e = 1'b0;
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      chk("missed_event_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      if (e.err) ev_e = 1'b1;
      else begin
        ev_v    = 1'b1;
        m_speed = e.spd;
      end
    end
    chk("speed_valid", 32'(bus.speed_valid), 32'(ev_v));
    chk("period_err", 32'(bus.period_err), 32'(ev_e));
    chk("speed", 32'(bus.speed), 32'(m_speed));
  endtask

  task automatic step(input bit v);
    bus.pwm_in = v;
    @(posedge clk);
    cyc++;
    if (arst) model_edge(v);
    #1;
    if (mon_en) monitor();
  endtask

  task automatic gen_steps(input int code, input int n);
    repeat (n) begin
      step(g_ph < code);
      g_ph = (g_ph + 1) % P;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_speed"}, 32'(bus.speed), 0);
    chk({tag, "_speed_valid"}, 32'(bus.speed_valid), 0);
    chk({tag, "_period_err"}, 32'(bus.period_err), 0);
    chk({tag, "_stuck_low"}, 32'(bus.stuck_low), 0);
    chk({tag, "_stuck_high"}, 32'(bus.stuck_high), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    int ecnt;
    int first;
    int per;
    int hi;
    int bper[5];

    tbl[0] = '{code: 64,  exp_speed: 8'd64};
    tbl[1] = '{code: 1,   exp_speed: 8'd1};
    tbl[2] = '{code: 128, exp_speed: 8'd128};
    tbl[3] = '{code: 255, exp_speed: 8'd255};
    tbl[4] = '{code: 2,   exp_speed: 8'd2};
    tbl[5] = '{code: 200, exp_speed: 8'd200};
    tbl[6] = '{code: 254, exp_speed: 8'd254};
    tbl[7] = '{code: 100, exp_speed: 8'd100};

    bus.pwm_in = 1'b0;
    arst       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Generator loopback over the code table.
    arst = 1'b1;
    model_reset(SPEED_MIN);
    mon_en = 1'b1;
    g_ph   = 0;
    for (int i = 0; i < 8; i++) begin
      gen_steps(tbl[i].code, 3 * P);
      chk("tbl_speed", 32'(bus.speed), 32'(tbl[i].exp_speed));
      chk("tbl_stuck_low", 32'(bus.stuck_low), 0);
      chk("tbl_stuck_high", 32'(bus.stuck_high), 0);
    end

    // Wrong period: 300 cycles with 100 high; speed must hold at 64.
    gen_steps(64, 2 * P);
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 300; j++) step(j < 100);
    end
    chk("bad_period_speed_held", 32'(bus.speed), 64);

    // Line stuck low after reset, then recovery with code 10.
    mon_en = 1'b0;
    arst   = 1'b0;
    repeat (2) step(1'b0);
    arst  = 1'b1;
    vcnt  = 0;
    first = -1;
    for (int k = 1; k <= 600; k++) begin
      step(1'b0);
      if (bus.speed_valid) vcnt++;
      if (bus.stuck_low && first < 0) first = k;
      if (k == 500) chk("stuck_low_early", 32'(bus.stuck_low), 0);
    end
    chk("stuck_low_timing", 32'(first >= 505 && first <= 530), 1);
    chk("stuck_low_flag", 32'(bus.stuck_low), 1);
    chk("stuck_low_speed", 32'(bus.speed), 0);
    chk("stuck_low_valid_cnt", 32'(vcnt), 1);
    chk("stuck_low_no_high", 32'(bus.stuck_high), 0);
    model_reset(SPEED_MIN);
    mon_en = 1'b1;
    g_ph   = 0;
    gen_steps(10, 3 * P);
    chk("stuck_low_cleared", 32'(bus.stuck_low), 0);
    chk("stuck_low_recover_speed", 32'(bus.speed), 10);

    // Line stuck high for 600 cycles, then released.
    mon_en = 1'b0;
    arst   = 1'b0;
    repeat (2) step(1'b0);
    arst = 1'b1;
    vcnt = 0;
    ecnt = 0;
    for (int k = 1; k <= 600; k++) begin
      step(1'b1);
      if (bus.speed_valid) vcnt++;
      if (bus.period_err) ecnt++;
    end
    chk("stuck_high_flag", 32'(bus.stuck_high), 1);
    chk("stuck_high_speed", 32'(bus.speed), 255);
    chk("stuck_high_valid_cnt", 32'(vcnt), 1);
    chk("stuck_high_err_cnt", 32'(ecnt), 0);
    chk("stuck_high_no_low", 32'(bus.stuck_low), 0);
    repeat (10) step(1'b0);
    chk("stuck_high_cleared", 32'(bus.stuck_high), 0);
    chk("stuck_high_speed_held", 32'(bus.speed), 255);
    model_reset(SPEED_MAX);
    mon_en = 1'b1;
    g_ph   = 0;
    gen_steps(64, 3 * P);
    chk("after_stuck_high_speed", 32'(bus.speed), 64);

    // Reset for 3 cycles in the low phase of a code-64 period.
    gen_steps(64, 150);
    mon_en = 1'b0;
    arst   = 1'b0;
    #1;
    check_all_zero("midreset");
    gen_steps(64, 3);
    arst = 1'b1;
    model_reset(SPEED_MIN);
    mon_en = 1'b1;
    gen_steps(64, (P - 153) + 3 * P);
    chk("midreset_recover_speed", 32'(bus.speed), 64);

    // Tolerance boundaries, then randomized periods and high times.
    bper = '{P - 2, P + 2, P - 3, P + 3, P};
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < bper[i]; j++) step(j < 50);
    end
    for (int n = 0; n < 40; n++) begin
      per = $urandom_range(P + 4, P - 4);
      hi  = $urandom_range(per - 1, 1);
      for (int j = 0; j < per; j++) step(j < hi);
    end
    repeat (10) step(1'b0);
    chk("queue_drained", 32'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
